// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared state type and default timing for the FTDI bus arbiter
package ftdi_pkg;

    localparam int RD_CYC_DEF    = 2;
    localparam int WR_CYC_DEF    = 2;
    localparam int RECOV_CYC_DEF = 3;
    localparam int CNT_W         = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_REC,
        WR_SETUP,
        WR_LOW,
        WR_HOLD,
        TURN
    } state_t;

    // Terminal count for a phase lasting the given number of cycles.
    function automatic cnt_t last_cnt(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/ftdi_bus_arbiter_if.sv
// rtl/ftdi_bus_arbiter_if.sv - rx/tx byte stream interface between arbiter and user logic
interface ftdi_bus_arbiter_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/ftdi_bus_arbiter_sync2.sv
// rtl/ftdi_bus_arbiter_sync2.sv - two-flop synchronizer, resets to 1 (inactive FTDI flag)
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ftdi_bus_arbiter.sv
// rtl/ftdi_bus_arbiter.sv - FTDI FIFO read/write arbiter; FTDI_BYTE_COUNT_EN adds rd_count/wr_count
module ftdi_bus_arbiter
    import ftdi_pkg::*;
#(
    parameter int RD_CYC    = RD_CYC_DEF,
    parameter int WR_CYC    = WR_CYC_DEF,
    parameter int RECOV_CYC = RECOV_CYC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rxf_n,
    input  logic        txe_n,
    output logic        ftdi_rd_n,
    output logic        ftdi_wr_n,
    input  logic [7:0]  adbus_in,
    output logic [7:0]  adbus_out,
    output logic        adbus_oe,
`ifdef FTDI_BYTE_COUNT_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    ftdi_bus_arbiter_if.master strm
);

    state_t     state, state_nx;
    cnt_t       cnt, cnt_nx;
    logic       rxf_s, txe_s;
    logic       rx_full, tx_full;
    logic [7:0] rx_reg, tx_reg;
    logic       last_rd;
    logic       rd_req, wr_req, grant_rd, grant_wr;
    logic       capture, tx_done;

    sync2 u_sync_rxf (.clock(clock), .reset(reset), .d(rxf_n), .q(rxf_s));
    sync2 u_sync_txe (.clock(clock), .reset(reset), .d(txe_n), .q(txe_s));

    assign rd_req   = en & ~rx_full & ~rxf_s;
    assign wr_req   = en &  tx_full & ~txe_s;
    // On a tie the direction that was not served last wins.
    assign grant_rd = (state == IDLE) & rd_req & (~wr_req | ~last_rd);
    assign grant_wr = (state == IDLE) & wr_req & (~rd_req |  last_rd);
    assign capture  = (state == RD_LOW) & (cnt == last_cnt(RD_CYC));
    assign tx_done  = (state == WR_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + cnt_t'(1);
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (grant_rd)      state_nx = RD_LOW;
                else if (grant_wr) state_nx = WR_SETUP;
            end
            RD_LOW: if (cnt == last_cnt(RD_CYC)) begin
                state_nx = RD_REC;
                cnt_nx   = '0;
            end
            RD_REC: if (cnt == last_cnt(RECOV_CYC)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            WR_SETUP: begin
                state_nx = WR_LOW;
                cnt_nx   = '0;
            end
            WR_LOW: if (cnt == last_cnt(WR_CYC)) begin
                state_nx = WR_HOLD;
                cnt_nx   = '0;
            end
            WR_HOLD: begin
                state_nx = TURN;
                cnt_nx   = '0;
            end
            TURN: if (cnt == last_cnt(RECOV_CYC)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Bus is driven only in write states, so it can never overlap a read strobe.
    always_comb begin
        ftdi_rd_n = 1'b1;
        ftdi_wr_n = 1'b1;
        adbus_oe  = 1'b0;
        case (state)
            RD_LOW:            ftdi_rd_n = 1'b0;
            WR_SETUP, WR_HOLD: adbus_oe  = 1'b1;
            WR_LOW: begin
                adbus_oe  = 1'b1;
                ftdi_wr_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign adbus_out = adbus_oe ? tx_reg : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_full <= 1'b0;
            rx_reg  <= 8'h00;
            tx_full <= 1'b0;
            tx_reg  <= 8'h00;
            last_rd <= 1'b0;
        end else begin
            if (capture) begin
                rx_reg  <= adbus_in;
                rx_full <= 1'b1;
            end else if (rx_full & strm.rx_ready) begin
                rx_full <= 1'b0;
            end
            if (strm.tx_valid & strm.tx_ready) begin
                tx_reg  <= strm.tx_data;
                tx_full <= 1'b1;
            end else if (tx_done) begin
                tx_full <= 1'b0;
            end
            if (grant_rd)      last_rd <= 1'b1;
            else if (grant_wr) last_rd <= 1'b0;
        end
    end

    assign strm.rx_valid = rx_full;
    assign strm.rx_data  = rx_reg;
    assign strm.tx_ready = ~tx_full & ~reset;

`ifdef FTDI_BYTE_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else begin
            if (capture) rd_count <= rd_count + 16'd1;
            if (tx_done) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ftdi_bus_arbiter.sv
// tb/tb_ftdi_bus_arbiter.sv - self-checking bench for ftdi_bus_arbiter; honours FTDI_BYTE_COUNT_EN
module tb_ftdi_bus_arbiter;
    import ftdi_pkg::*;

    localparam int RD = RD_CYC_DEF;
    localparam int WR = WR_CYC_DEF;
    localparam int RC = RECOV_CYC_DEF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       rxf_n = 1'b1;
    logic       txe_n = 1'b1;
    logic       ftdi_rd_n, ftdi_wr_n, adbus_oe;
    logic [7:0] adbus_in = 8'h00;
    logic [7:0] adbus_out;
`ifdef FTDI_BYTE_COUNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ftdi_bus_arbiter_if bus ();

    ftdi_bus_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .ftdi_rd_n (ftdi_rd_n),
        .ftdi_wr_n (ftdi_wr_n),
        .adbus_in  (adbus_in),
        .adbus_out (adbus_out),
        .adbus_oe  (adbus_oe),
`ifdef FTDI_BYTE_COUNT_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .strm      (bus)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each grant expands into a per-cycle schedule of pin levels.
    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic oe;
        logic cap;
        logic done;
    } step_t;

    function automatic step_t st(input logic rd_n, input logic wr_n, input logic oe,
                                 input logic cap, input logic done);
        step_t s;
        s.rd_n = rd_n; s.wr_n = wr_n; s.oe = oe; s.cap = cap; s.done = done;
        return s;
    endfunction

    step_t      sched[$];
    step_t      cur, exp_s;
    logic       m_rx_full, m_tx_full, m_last_rd, m_rreq, m_wreq;
    logic [7:0] m_rx_data, m_tx_reg;
    logic [1:0] rxf_h, txe_h;
    logic [15:0] m_rd_cnt, m_wr_cnt;

    always @(posedge clock) begin
        if (reset) begin
            sched.delete();
            m_rx_full = 1'b0; m_rx_data = 8'h00;
            m_tx_full = 1'b0; m_tx_reg  = 8'h00;
            m_last_rd = 1'b0;
            rxf_h = 2'b11; txe_h = 2'b11;
            m_rd_cnt = 16'h0; m_wr_cnt = 16'h0;
        end else begin
            cur    = st(1, 1, 0, 0, 0);
            m_rreq = en && !m_rx_full && !rxf_h[1];
            m_wreq = en &&  m_tx_full && !txe_h[1];
            if (sched.size() == 0) begin
                if (m_rreq && (!m_wreq || !m_last_rd)) begin
                    for (int i = 0; i < RD; i++) sched.push_back(st(0, 1, 0, (i == RD - 1), 0));
                    for (int i = 0; i < RC; i++) sched.push_back(st(1, 1, 0, 0, 0));
                    m_last_rd = 1'b1;
                end else if (m_wreq) begin
                    sched.push_back(st(1, 1, 1, 0, 0));
                    for (int i = 0; i < WR; i++) sched.push_back(st(1, 0, 1, 0, 0));
                    sched.push_back(st(1, 1, 1, 0, 1));
                    for (int i = 0; i < RC; i++) sched.push_back(st(1, 1, 0, 0, 0));
                    m_last_rd = 1'b0;
                end
            end else begin
                cur = sched.pop_front();
            end
            if (cur.cap) begin
                m_rx_full = 1'b1; m_rx_data = adbus_in; m_rd_cnt = m_rd_cnt + 16'd1;
            end else if (m_rx_full && bus.rx_ready) begin
                m_rx_full = 1'b0;
            end
            if (bus.tx_valid && !m_tx_full) begin
                m_tx_full = 1'b1; m_tx_reg = bus.tx_data;
            end else if (cur.done) begin
                m_tx_full = 1'b0; m_wr_cnt = m_wr_cnt + 16'd1;
            end
            rxf_h = {rxf_h[0], rxf_n};
            txe_h = {txe_h[0], txe_n};
        end
    end

    always @(negedge clock) begin
        exp_s = (sched.size() != 0) ? sched[0] : st(1, 1, 0, 0, 0);
        chk1("ftdi_rd_n", ftdi_rd_n, exp_s.rd_n);
        chk1("ftdi_wr_n", ftdi_wr_n, exp_s.wr_n);
        chk1("adbus_oe", adbus_oe, exp_s.oe);
        chk8("adbus_out", adbus_out, exp_s.oe ? m_tx_reg : 8'h00);
        chk1("rx_valid", bus.rx_valid, m_rx_full);
        chk8("rx_data", bus.rx_data, m_rx_data);
        chk1("tx_ready", bus.tx_ready, !m_tx_full && !reset);
        chk1("strobe_exclusion", !ftdi_rd_n && (adbus_oe || !ftdi_wr_n), 1'b0);
`ifdef FTDI_BYTE_COUNT_EN
        chk16("rd_count", rd_count, m_rd_cnt);
        chk16("wr_count", wr_count, m_wr_cnt);
`endif
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        en = 1'b0; rxf_n = 1'b1; txe_n = 1'b1;
        bus.rx_ready = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) step();
        reset = 1'b0;
    endtask

    // sel: 0 = rd_n low, 1 = wr_n low, 2 = adbus_oe high
    task automatic wait_for(input int sel, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            hit = (sel == 0) ? !ftdi_rd_n : (sel == 1) ? !ftdi_wr_n : adbus_oe;
        end
    endtask

    task automatic count_strobes(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (!ftdi_rd_n || !ftdi_wr_n) lows++;
        end
    endtask

    bit  hit;
    int  lows;
    byte order[$];
    logic prev_rd, prev_wr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and first cycle after release.
        reset = 1'b1;
        idle_inputs();
        repeat (3) step();
        chk1("rst_rd_n", ftdi_rd_n, 1'b1);
        chk1("rst_wr_n", ftdi_wr_n, 1'b1);
        chk1("rst_oe", adbus_oe, 1'b0);
        chk8("rst_adbus_out", adbus_out, 8'h00);
        chk1("rst_rx_valid", bus.rx_valid, 1'b0);
        chk8("rst_rx_data", bus.rx_data, 8'h00);
        chk1("rst_tx_ready", bus.tx_ready, 1'b0);
        reset = 1'b0;
        #1 chk1("tx_ready_after_reset", bus.tx_ready, 1'b1);

        // Read of 8'hA5: strobe falls on the third edge, held two cycles.
        en = 1'b1; adbus_in = 8'hA5; rxf_n = 1'b0;
        step(); chk1("rd_lat_edge1", ftdi_rd_n, 1'b1);
        step(); chk1("rd_lat_edge2", ftdi_rd_n, 1'b1);
        step(); chk1("rd_lat_edge3", ftdi_rd_n, 1'b0);
        step(); chk1("rd_low_cycle2", ftdi_rd_n, 1'b0);
        step(); chk1("rd_released", ftdi_rd_n, 1'b1);
        chk1("rd_valid", bus.rx_valid, 1'b1);
        chk8("rd_data_a5", bus.rx_data, 8'hA5);
        count_strobes(12, lows);
        chk8("no_read_while_full", 8'(lows), 8'd0);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        chk1("rx_drained", bus.rx_valid, 1'b0);
        wait_for(0, hit);
        chk1("second_read_after_drain", hit, 1'b1);

        // Write of 8'h3C.
        do_reset();
        en = 1'b1; txe_n = 1'b0; bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        chk1("tx_loaded_not_ready", bus.tx_ready, 1'b0);
        wait_for(2, hit);
        chk1("wr_setup_seen", hit, 1'b1);
        chk1("wr_setup_wr_n", ftdi_wr_n, 1'b1);
        chk8("wr_setup_data", adbus_out, 8'h3C);
        step(); chk1("wr_low1", ftdi_wr_n, 1'b0); chk8("wr_low1_data", adbus_out, 8'h3C);
        step(); chk1("wr_low2", ftdi_wr_n, 1'b0); chk8("wr_low2_data", adbus_out, 8'h3C);
        step(); chk1("wr_hold_wr_n", ftdi_wr_n, 1'b1); chk1("wr_hold_oe", adbus_oe, 1'b1);
        chk8("wr_hold_data", adbus_out, 8'h3C);
        step(); chk1("turn_oe", adbus_oe, 1'b0); chk1("tx_ready_back", bus.tx_ready, 1'b1);

        // Contention: both flags low, tx refilled and rx drained continuously.
        do_reset();
        en = 1'b1; rxf_n = 1'b0; txe_n = 1'b0; adbus_in = 8'h11;
        bus.tx_valid = 1'b1; bus.tx_data = 8'h5A; bus.rx_ready = 1'b1;
        order.delete();
        prev_rd = 1'b1; prev_wr = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (prev_rd && !ftdi_rd_n) order.push_back("R");
            if (prev_wr && !ftdi_wr_n) order.push_back("W");
            prev_rd = ftdi_rd_n; prev_wr = ftdi_wr_n;
        end
        chk1("contention_4_strobes", order.size() >= 4, 1'b1);
        if (order.size() >= 4) begin
            chk8("order0", order[0], "R");
            chk8("order1", order[1], "W");
            chk8("order2", order[2], "R");
            chk8("order3", order[3], "W");
        end

        // Reset in the middle of WR_LOW discards the pending byte.
        do_reset();
        en = 1'b1; txe_n = 1'b0; bus.tx_data = 8'h77; bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        wait_for(1, hit);
        chk1("wr_low_reached", hit, 1'b1);
        reset = 1'b1;
        step();
        chk1("midrst_wr_n", ftdi_wr_n, 1'b1);
        chk1("midrst_oe", adbus_oe, 1'b0);
        reset = 1'b0;
        #1 chk1("midrst_tx_ready", bus.tx_ready, 1'b1);
        count_strobes(15, lows);
        chk8("no_stale_write", 8'(lows), 8'd0);

        // en low blocks grants; dropping en mid-read lets the read finish.
        do_reset();
        bus.tx_data = 8'h42; bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        rxf_n = 1'b0; txe_n = 1'b0; adbus_in = 8'hC3;
        count_strobes(12, lows);
        chk8("en_low_no_strobe", 8'(lows), 8'd0);
        en = 1'b1;
        wait_for(0, hit);
        chk1("en_read_started", hit, 1'b1);
        en = 1'b0;
        repeat (RD + RC) step();
        chk1("en_read_completed", bus.rx_valid, 1'b1);
        chk8("en_read_data", bus.rx_data, 8'hC3);
        count_strobes(12, lows);
        chk8("en_stays_idle", 8'(lows), 8'd0);
        chk1("en_write_pending", bus.tx_ready, 1'b0);

`ifdef FTDI_BYTE_COUNT_EN
        do_reset();
        dut.rd_count = 16'hFFFF;
        m_rd_cnt     = 16'hFFFF;
        en = 1'b1; rxf_n = 1'b0;
        wait_for(0, hit);
        repeat (RD) step();
        chk16("rd_count_wrap", rd_count, 16'h0000);
`endif

        // Randomised traffic, checked every cycle by the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) rxf_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) txe_n = 1'($urandom_range(0, 1));
            bus.rx_ready = 1'($urandom_range(0, 1));
            bus.tx_valid = 1'($urandom_range(0, 1));
            bus.tx_data  = 8'($urandom);
            adbus_in     = 8'($urandom);
            step();
        end
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
